// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared definitions for the seven-segment bus capture block: the
// active-low one-hot select codes, the capture state machine encoding,
// the largest score that fits the 10-bit output, and a select-code decoder.
// No ports (package).
package ssd_pkg;

  localparam logic [3:0] SSD_SEL0  = 4'b1110;
  localparam logic [3:0] SSD_SEL1  = 4'b1101;
  localparam logic [3:0] SSD_SEL2  = 4'b1011;
  localparam logic [3:0] SSD_SEL3  = 4'b0111;
  localparam logic [3:0] SSD_BLANK = 4'b1111;

  localparam int SSD_MAX_SCORE = 1023;

  typedef enum logic {
    COLLECT = 1'b0,
    CONVERT = 1'b1
  } ssd_cap_state_t;

  // Decoded view of a select code: a legal single digit, the blank code,
  // or (neither flag set) a malformed multi-hot / all-zero code.
  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [1:0] sel;
  } ssd_sel_t;

  function automatic ssd_sel_t ssd_decode(input logic [3:0] ctl);
    ssd_sel_t d;
    d = '0;
    case (ctl)
      SSD_SEL0:  begin d.legal = 1'b1; d.sel = 2'd0; end
      SSD_SEL1:  begin d.legal = 1'b1; d.sel = 2'd1; end
      SSD_SEL2:  begin d.legal = 1'b1; d.sel = 2'd2; end
      SSD_SEL3:  begin d.legal = 1'b1; d.sel = 2'd3; end
      SSD_BLANK: d.blank = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ssd_capture_if.sv
// ssd_capture_if
// Bundles the multiplexed display bus and the decoded results.
//   ssd_ctl     : active-low one-hot digit select (1111 = blank)
//   digit       : BCD value of the selected digit
//   score       : last good decoded score
//   score_valid : one-cycle pulse when score updates
//   frame_err   : one-cycle pulse on a rejected frame / illegal select
//   digits      : last good frame {d3,d2,d1,d0}
// master drives the display bus, slave is the capture block.
interface ssd_capture_if;
  logic [3:0]  ssd_ctl;
  logic [3:0]  digit;
  logic [9:0]  score;
  logic        score_valid;
  logic        frame_err;
  logic [15:0] digits;

  modport master (
    output ssd_ctl, digit,
    input  score, score_valid, frame_err, digits
  );

  modport slave (
    input  ssd_ctl, digit,
    output score, score_valid, frame_err, digits
  );
endinterface

// File: rtl/ssd_bcd2bin.sv
// ssd_bcd2bin
// Four-step sequential multiply-accumulate turning a BCD frame into binary.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse; the first step (digit3) runs in this cycle
//   frame     : {d3,d2,d1,d0}, must stay stable for the four steps
//   done      : high during the fourth step; result/range_err valid then
//   result    : low 10 bits of the accumulated value
//   range_err : a digit was above 9 or the value exceeds SSD_MAX_SCORE
module ssd_bcd2bin
  import ssd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0][3:0] frame,
  output logic            done,
  output logic [9:0]      result,
  output logic            range_err
);

  logic [13:0] acc;
  logic [1:0]  step;
  logic        busy;
  logic        bad;

  logic        active;
  logic [1:0]  step_eff;
  logic [3:0]  cur;
  logic [13:0] acc_base;
  logic [13:0] acc_next;
  logic        bad_next;

  // The step in progress is computed combinationally so the caller sees
  // done and the final value in the fourth cycle and can register them
  // directly. Non-BCD digits can wrap the 14-bit accumulator, but they are
  // flagged through bad_next so the wrapped value is never used.
  always_comb begin
    active    = start | busy;
    step_eff  = start ? 2'd0 : step;
    cur       = frame[2'd3 - step_eff];
    acc_base  = start ? 14'd0 : acc;
    acc_next  = (acc_base * 14'd10) + {10'd0, cur};
    bad_next  = (start ? 1'b0 : bad) | (cur > 4'd9);
    done      = active && (step_eff == 2'd3);
    result    = acc_next[9:0];
    range_err = bad_next || (acc_next > 14'(SSD_MAX_SCORE));
  end

  // Accumulator and step counter advance only while a conversion runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      step <= '0;
      busy <= 1'b0;
      bad  <= 1'b0;
    end else if (active) begin
      acc  <= acc_next;
      bad  <= bad_next;
      step <= step_eff + 2'd1;
      busy <= (step_eff != 2'd3);
    end
  end

endmodule

// File: rtl/ssd_capture.sv
// ssd_capture
// Watches a multiplexed four-digit seven-segment scan bus, rebuilds the
// displayed BCD digits, converts each complete frame to a 10-bit score and
// flags malformed frames.
//   SETTLE : cycles a select code must be held before its digit is sampled
//   clk    : system clock (rising edge)
//   rst    : synchronous active-high reset
//   bus    : ssd_capture_if.slave (ssd_ctl/digit in; score, score_valid,
//            frame_err, digits out)
// Optional feature: define SSD_CAPTURE_ORDER_CHECK_EN to require captures
// in scan order 0,1,2,3; otherwise any order completes a frame.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int SETTLE = 16
) (
  input logic           clk,
  input logic           rst,
  ssd_capture_if.slave  bus
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] DWELL_SAT = CW'(SETTLE);
  localparam logic [CW-1:0] DWELL_HIT = CW'(SETTLE - 1);

  ssd_cap_state_t  state;
  logic [3:0]      prev_ctl;
  logic [CW-1:0]   dwell_q;
  logic [CW-1:0]   dwell_eff;
  logic            dwell_hit;
  ssd_sel_t        dec;
  logic            cap;
  logic            bad_code;
  logic            accept;
  logic            order_err;
  logic            bus_err;
  logic [3:0][3:0] slots;
  logic [3:0][3:0] slot_next;
  logic [3:0][3:0] frame_q;
  logic [3:0]      seen;
  logic [3:0]      seen_next;
  logic            frame_done;
  logic            conv_start;
  logic            conv_done;
  logic            conv_range_err;
  logic [9:0]      conv_result;
  logic [9:0]      score_q;
  logic [15:0]     digits_q;
  logic            score_valid_q;
  logic            frame_err_q;

  // dwell_eff counts how many consecutive cycles, including this one, the
  // current code has been present beyond the first. It saturates one past
  // the hit value so a long dwell fires exactly once.
  always_comb begin
    dec = ssd_decode(bus.ssd_ctl);
    if (bus.ssd_ctl != prev_ctl) begin
      dwell_eff = '0;
    end else if (dwell_q == DWELL_SAT) begin
      dwell_eff = dwell_q;
    end else begin
      dwell_eff = dwell_q + CW'(1);
    end
    dwell_hit = (bus.ssd_ctl == prev_ctl) && (dwell_eff == DWELL_HIT);
    cap       = dwell_hit & dec.legal;
    bad_code  = dwell_hit & ~dec.legal & ~dec.blank;
  end

`ifdef SSD_CAPTURE_ORDER_CHECK_EN
  logic       synced;
  logic [1:0] exp_sel;

  // Until a digit0 is seen, captures are dropped silently; after that any
  // out-of-sequence capture is an error, and a digit0 arriving out of
  // sequence immediately starts the next frame.
  always_comb begin
    accept    = 1'b0;
    order_err = 1'b0;
    if (cap) begin
      if (!synced) begin
        accept = (dec.sel == 2'd0);
      end else if (dec.sel == exp_sel) begin
        accept = 1'b1;
      end else begin
        order_err = 1'b1;
        accept    = (dec.sel == 2'd0);
      end
    end
  end

  // Scan-order tracker; an illegal select code also loses synchronisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      synced  <= 1'b0;
      exp_sel <= 2'd0;
    end else if (accept) begin
      synced  <= 1'b1;
      exp_sel <= dec.sel + 2'd1;
    end else if (order_err || bad_code) begin
      synced  <= 1'b0;
    end
  end
`else
  // Without the order check every legal capture is taken.
  always_comb begin
    accept    = cap;
    order_err = 1'b0;
  end
`endif

  // Next slot contents and seen bits. An error throws away the partial
  // frame before the (possible) new digit is recorded.
  always_comb begin
    bus_err   = bad_code | order_err;
    slot_next = slots;
    seen_next = bus_err ? 4'b0000 : seen;
    if (accept) begin
      slot_next[dec.sel] = bus.digit;
      seen_next[dec.sel] = 1'b1;
    end
    frame_done = (state == COLLECT) && (seen_next == 4'hF);
  end

  // Main state machine. The frame is copied into frame_q on entry to
  // CONVERT so the slots keep collecting the next frame meanwhile. If a
  // bus error lands in the very cycle a conversion finishes, the
  // conversion outcome is reported and the bus error only discards the
  // partial frame, keeping score_valid and frame_err mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      prev_ctl      <= SSD_BLANK;
      dwell_q       <= '0;
      slots         <= '0;
      seen          <= '0;
      frame_q       <= '0;
      conv_start    <= 1'b0;
      score_q       <= '0;
      digits_q      <= '0;
      score_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      prev_ctl      <= bus.ssd_ctl;
      dwell_q       <= dwell_eff;
      slots         <= slot_next;
      conv_start    <= 1'b0;
      score_valid_q <= 1'b0;
      frame_err_q   <= bus_err;
      seen          <= seen_next;
      case (state)
        COLLECT: begin
          if (frame_done) begin
            state      <= CONVERT;
            frame_q    <= slot_next;
            seen       <= 4'b0000;
            conv_start <= 1'b1;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            state <= COLLECT;
            if (conv_range_err) begin
              frame_err_q <= 1'b1;
            end else begin
              frame_err_q   <= 1'b0;
              score_q       <= conv_result;
              digits_q      <= frame_q;
              score_valid_q <= 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  ssd_bcd2bin u_bcd2bin (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .frame     (frame_q),
    .done      (conv_done),
    .result    (conv_result),
    .range_err (conv_range_err)
  );

  assign bus.score       = score_q;
  assign bus.digits      = digits_q;
  assign bus.score_valid = score_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture
// Directed bench for ssd_capture: stimulus pushes expected pulses into a
// scoreboard queue, a negedge monitor pops and compares each pulse.
// Honours SSD_CAPTURE_ORDER_CHECK_EN when the design is built with it.
module tb_ssd_capture;
  import ssd_pkg::*;

  localparam int SETTLE = 16;
  localparam int DWELL  = 64;

  typedef struct {
    logic        is_err;
    logic [9:0]  score;
    logic [15:0] digits;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_pulse_cyc = -1;
  int   t_digit3 = 0;
  exp_t sb_q[$];

  ssd_capture_if bus();

  ssd_capture #(.SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Hold one bus value for a number of cycles; always returns #1 after a
  // rising edge so the next drive is away from the active edge.
  task automatic applyStimulus(input logic [3:0] ctl, input logic [3:0] dig,
                               input int cycles);
    bus.ssd_ctl = ctl;
    bus.digit   = dig;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_frame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    applyStimulus(SSD_SEL0, d0, DWELL);
    applyStimulus(SSD_SEL1, d1, DWELL);
    applyStimulus(SSD_SEL2, d2, DWELL);
    t_digit3 = cyc;
    applyStimulus(SSD_SEL3, d3, DWELL);
  endtask

  task automatic push_exp(input logic is_err, input logic [9:0] score,
                          input logic [15:0] digits);
    exp_t e;
    e.is_err = is_err;
    e.score  = score;
    e.digits = digits;
    sb_q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    repeat (8) @(posedge clk);
    #1;
    checkOutput(name, 16'(sb_q.size()), 16'd0);
  endtask

  // Monitor: every pulse must match the oldest expected entry; a pulse with
  // nothing expected is a failure on its own.
  always @(negedge clk) begin
    if (bus.score_valid || bus.frame_err) begin
      exp_t e;
      last_pulse_cyc = cyc;
      checkOutput("pulse_excl", {15'd0, bus.score_valid & bus.frame_err}, 16'd0);
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b score=%0d required no pulse",
                 bus.score_valid, bus.frame_err, bus.score);
      end else begin
        e = sb_q.pop_front();
        checkOutput("pulse_kind", {15'd0, bus.frame_err}, {15'd0, e.is_err});
        checkOutput("score", {6'd0, bus.score}, {6'd0, e.score});
        checkOutput("digits", bus.digits, e.digits);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.ssd_ctl = SSD_BLANK;
    bus.digit   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_score", {6'd0, bus.score}, 16'd0);
    checkOutput("rst_digits", bus.digits, 16'd0);
    checkOutput("rst_valid", {15'd0, bus.score_valid}, 16'd0);
    checkOutput("rst_err", {15'd0, bus.frame_err}, 16'd0);
    applyStimulus(SSD_BLANK, 4'd0, 4);

    $display("[TB] frame 7,3,4,0 -> 437");
    push_exp(1'b0, 10'd437, 16'h0437);
    scan_frame(4'd7, 4'd3, 4'd4, 4'd0);
    drain_check("drain_437");
    checkOutput("latency", 16'(last_pulse_cyc - t_digit3), 16'(SETTLE + 4));

    $display("[TB] frame 1023 then 1024");
    push_exp(1'b0, 10'd1023, 16'h1023);
    scan_frame(4'd3, 4'd2, 4'd0, 4'd1);
    drain_check("drain_1023");
    push_exp(1'b1, 10'd1023, 16'h1023);
    scan_frame(4'd4, 4'd2, 4'd0, 4'd1);
    drain_check("drain_1024");

    $display("[TB] non-BCD digit2");
    push_exp(1'b1, 10'd1023, 16'h1023);
    scan_frame(4'd5, 4'd6, 4'hA, 4'd0);
    drain_check("drain_bcd");

`ifndef SSD_CAPTURE_ORDER_CHECK_EN
    $display("[TB] short glitch inside digit0 dwell");
    applyStimulus(SSD_SEL0, 4'd9, 5);
    applyStimulus(SSD_SEL2, 4'd7, SETTLE - 1);
    applyStimulus(SSD_SEL0, 4'd9, DWELL);
    applyStimulus(SSD_SEL1, 4'd1, DWELL);
    applyStimulus(SSD_SEL3, 4'd0, DWELL);
    drain_check("glitch_no_frame");
    push_exp(1'b0, 10'd219, 16'h0219);
    applyStimulus(SSD_SEL2, 4'd2, DWELL);
    drain_check("drain_219");

    $display("[TB] multi-hot select drops partial frame");
    applyStimulus(SSD_SEL0, 4'd1, DWELL);
    applyStimulus(SSD_SEL1, 4'd2, DWELL);
    push_exp(1'b1, 10'd219, 16'h0219);
    applyStimulus(4'b1100, 4'd0, 20);
    drain_check("drain_multihot");
    applyStimulus(SSD_SEL2, 4'd3, DWELL);
    applyStimulus(SSD_SEL3, 4'd0, DWELL);
    drain_check("partial_dropped");
    push_exp(1'b0, 10'd354, 16'h0354);
    applyStimulus(SSD_SEL0, 4'd4, DWELL);
    applyStimulus(SSD_SEL1, 4'd5, DWELL);
    drain_check("drain_354");
`else
    $display("[TB] out-of-order capture");
    push_exp(1'b1, 10'd1023, 16'h1023);
    applyStimulus(SSD_SEL0, 4'd0, DWELL);
    applyStimulus(SSD_SEL1, 4'd0, DWELL);
    applyStimulus(SSD_SEL3, 4'd9, DWELL);
    drain_check("drain_order");
    push_exp(1'b0, 10'd500, 16'h0500);
    scan_frame(4'd0, 4'd0, 4'd5, 4'd0);
    drain_check("drain_500");
`endif

    $display("[TB] reset during CONVERT");
    applyStimulus(SSD_SEL0, 4'd1, DWELL);
    applyStimulus(SSD_SEL1, 4'd2, DWELL);
    applyStimulus(SSD_SEL2, 4'd3, DWELL);
    applyStimulus(SSD_SEL3, 4'd0, SETTLE + 1);
    rst         = 1'b1;
    bus.ssd_ctl = SSD_BLANK;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    checkOutput("abort_score", {6'd0, bus.score}, 16'd0);
    checkOutput("abort_digits", bus.digits, 16'd0);
    applyStimulus(SSD_BLANK, 4'd0, 30);
    drain_check("abort_no_pulse");
    push_exp(1'b0, 10'd321, 16'h0321);
    scan_frame(4'd1, 4'd2, 4'd3, 4'd0);
    drain_check("drain_321");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
